// File: rtl/decoder_scan_nx.sv
// -----------------------------------------------------------------------------
// decoder_scan_nx
//   Registered N-to-2^N one-hot (or one-cold) decoder with a global enable and
//   two operating modes. It is intended to drive row, digit or chip-select
//   strobes.
//     DIRECT : idx is set only by a load strobe, and y shows decode(idx).
//     SCAN   : idx steps 0..scan_last and then wraps to 0. Each index is held
//              for dwell+1 cycles, and wrap pulses on the step that returns to 0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (released synchronously upstream)
//   en         global enable; 0 forces y inactive and freezes all state
//   mode       0 = DIRECT, 1 = SCAN
//   load       1-cycle strobe: capture sel into idx (both modes)
//   sel        select code captured on load
//   scan_last  highest index visited in SCAN before wrapping to 0
//   dwell      extra hold cycles per SCAN step
//   y          registered decoded output (active level set by ACTIVE_LOW)
//   idx        registered current index
//   wrap       registered 1-cycle pulse when SCAN wraps to 0
//
// Handshake: there is no valid/ready pair. load is a plain strobe, sampled on
// every rising edge while en=1, and ignored while en=0.
// -----------------------------------------------------------------------------
module decoder_scan_nx #(
  parameter int N          = 3,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 load,
  input  logic [N-1:0]         sel,
  input  logic [N-1:0]         scan_last,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(2**N)-1:0]    y,
  output logic [N-1:0]         idx,
  output logic                 wrap
);

  localparam int OUT = 2**N;
  localparam logic [OUT-1:0] Y_IDLE = (ACTIVE_LOW != 0) ? {OUT{1'b1}} : {OUT{1'b0}};

  logic [DWELL_W-1:0] dwell_cnt;
  logic               mode_q;

  logic [N-1:0]       idx_next;
  logic [DWELL_W-1:0] cnt_next;
  logic               wrap_next;
  logic               mode_next;
  logic [OUT-1:0]     y_next;

  function automatic logic [OUT-1:0] decode(input logic [N-1:0] code);
    logic [OUT-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      dwell_cnt <= '0;
      wrap      <= 1'b0;
      mode_q    <= 1'b0;
      y         <= Y_IDLE;
    end else begin
      idx       <= idx_next;
      dwell_cnt <= cnt_next;
      wrap      <= wrap_next;
      mode_q    <= mode_next;
      y         <= y_next;
    end
  end

  // Next-state logic. Priority while enabled: load > mode change > scan step.
  always_comb begin
    idx_next  = idx;
    cnt_next  = dwell_cnt;
    wrap_next = 1'b0;
    mode_next = mode_q;
    if (en) begin
      mode_next = mode;
      if (load) begin
        idx_next = sel;
        cnt_next = '0;
      end else if (mode != mode_q) begin
        // A mode switch spends one cycle resetting the dwell counter without advancing.
        cnt_next = '0;
      end else if (mode) begin
        // ">=" ensures a live reduction of dwell below the current count advances at once.
        if (dwell_cnt >= dwell) begin
          cnt_next = '0;
          // ">=" also catches an idx left above scan_last by a DIRECT load.
          if (idx >= scan_last) begin
            idx_next  = '0;
            wrap_next = 1'b1;
          end else begin
            idx_next = idx + 1'b1;
          end
        end else begin
          cnt_next = dwell_cnt + 1'b1;
        end
      end else begin
        cnt_next = '0;
      end
    end
  end

  // Output logic: y tracks idx_next so that y and idx update on the same edge.
  always_comb begin
    y_next = Y_IDLE;
    if (en) y_next = decode(idx_next);
  end

endmodule
